synth_note_controller: RTL and testbench
========================================

# synth_note_controller

Note-event controller that sequences the sine synthesizer. It accepts note-on and note-off requests over a valid/ready handshake and holds one request in a single-entry buffer. On each audio sample tick it updates the phase increment fed to the synthesizer, with exponential glide between notes, and steps a linear attack/release amplitude envelope. It sits between the control path (MIDI/UI decode) and the synthesizer plus its output gain multiplier.

## Interface
Parameters:
- GLIDE_SHIFT, default 4: glide rate; each tick closes 1/2^GLIDE_SHIFT of the remaining distance. A value of 0 makes pitch changes immediate.
- ENV_BITS, default 16: width of the gain output.
- ENV_STEP, default 4096: gain change per tick during attack and release. Must satisfy 1 ≤ ENV_STEP < 2^ENV_BITS.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous, active-high reset.
- sample_tick_in, input, 1: one-cycle strobe at the audio sample rate.
- note_valid_in, input, 1: request valid.
- note_ready_out, output, 1: buffer slot empty, so a request can be accepted.
- note_on_in, input, 1: 1 = note-on, 0 = note-off.
- note_incr_in, input, SYNTH_PHASE_ACC_BITS: target phase increment. Ignored for note-off.
- phase_incr_out, output, SYNTH_PHASE_ACC_BITS: phase increment to the synthesizer. Registered.
- gain_out, output, ENV_BITS: unsigned envelope gain. Registered.
- active_out, output, 1: envelope state is not IDLE. Registered.

## Operation
- **Handshake**
  - A request transfers when note_valid_in and note_ready_out are both high at a rising edge. The request is captured into the one-entry slot.
  - note_ready_out is registered: it goes low the cycle after the transfer and high the cycle after the slot is consumed.
  - Requests are ignored while rst_in is high.
- **Slot consumption**
  - The slot is consumed on the first sample_tick_in strictly after the cycle of capture.
  - A request captured in a tick cycle waits for the next tick.
- **Envelope states:** IDLE, ATTACK, SUSTAIN, RELEASE. Define MAX = 2^ENV_BITS−1.
- **Note-on from IDLE:**
  - phase_incr_out loads the target directly, with no glide from silence.
  - gain starts from 0 and the state goes to ATTACK.
- **Note-on from ATTACK, SUSTAIN or RELEASE:**
  - The target is updated and pitch glides toward it.
  - The state goes to ATTACK. From RELEASE, the current gain is kept and ramps up from there.
- **Note-off:**
  - From ATTACK or SUSTAIN, the state goes to RELEASE.
  - In IDLE or RELEASE, note-off is a no-op.
- **Per tick with no slot consumed (or after applying it):**
  - ATTACK: if gain+ENV_STEP ≥ MAX, gain = MAX and the state goes to SUSTAIN; otherwise gain += ENV_STEP.
  - SUSTAIN: gain holds at MAX.
  - RELEASE: if gain ≤ ENV_STEP, gain = 0, the state goes to IDLE, and phase_incr_out goes to 0. Otherwise gain −= ENV_STEP.
- **Glide (each tick, when not IDLE):**
  - diff = target − current, computed signed at SYNTH_PHASE_ACC_BITS+1 bits.
  - If |diff| < 2^GLIDE_SHIFT, current = target (snap).
  - Otherwise current += diff >>> GLIDE_SHIFT, an arithmetic shift that floors toward −∞.
- **Tick that consumes a note-on:**
  - The state change and the first envelope step apply in the same tick. For example, from IDLE, gain becomes ENV_STEP after that tick.
  - Glide takes its first step toward the new target in the same tick. The exception is from IDLE, where phase_incr_out loads the target directly.
- No arithmetic wraps. Gain saturates at 0 and MAX; glide never overshoots the target.

## Timing
- Reset values:
  - phase_incr_out = 0, gain_out = 0, active_out = 0.
  - State IDLE, target = 0, slot empty.
  - note_ready_out = 1, including while rst_in is held.
- Reset mid-operation aborts any envelope or glide. The outputs take their reset values on the next edge, and a pending slot entry is discarded.
- All outputs change only on the edge ending a sample_tick_in cycle, and are visible the cycle after the tick. Between ticks they are static.
- Latency: a request accepted at cycle t affects the outputs one cycle after the first tick at a cycle greater than t.
- Maximum throughput is one request per tick interval. Back-to-back requests without an intervening tick stall on note_ready_out.

## Test plan
All cases use ENV_STEP=4096, ENV_BITS=16, GLIDE_SHIFT=4, with ticks every 8 cycles.
- **Attack from silence:** note-on with incr=1000 from reset.
  - After the first tick: phase_incr_out=1000, gain_out=4096, active_out=1.
  - After tick 15: gain_out=61440.
  - After tick 16: gain_out=65535, state SUSTAIN.
- **Glide up and down:**
  - In SUSTAIN at 1000, note-on with 2000: next tick gives 1062.
  - From 2000, note-on with 1000: next tick gives 1937.
  - Continued ticks converge exactly to the target, with no overshoot.
- **Release to idle:**
  - Note-off in SUSTAIN: gain drops by 4096 per tick.
  - The tick that reaches 0 sets gain_out=0, active_out=0, phase_incr_out=0.
- **Retrigger during release:**
  - Note-on at gain 20479 in RELEASE: next tick gives gain 24575, state ATTACK.
- **Handshake backpressure:**
  - Hold note_valid_in high across two requests: the second transfers only after the next tick consumes the first.
  - A request captured in a tick cycle takes effect on the following tick.
- **Reset mid-attack:**
  - Assert rst_in for 1 cycle at gain 8192 with a pending slot.
  - Next cycle: all outputs at reset values, note_ready_out=1, and the pending request is never applied.

Source files
------------

// File: rtl/synth_note_controller.sv
// synth_note_controller
//   Sequences the sine synthesizer from note-on / note-off requests. One
//   request is held in a single-entry slot. On each sample tick the slot is
//   applied, the phase increment glides exponentially toward its target, and
//   a linear attack/release envelope is stepped.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous, active-high reset
//   sample_tick_in  one-cycle strobe at the audio sample rate
//   note_valid_in   request valid
//   note_ready_out  slot empty, request can be accepted (registered)
//   note_on_in      1 = note-on, 0 = note-off
//   note_incr_in    target phase increment (ignored for note-off)
//   phase_incr_out  phase increment to the synthesizer (registered)
//   gain_out        unsigned envelope gain (registered)
//   active_out      envelope is not idle (registered)
module synth_note_controller #(
  parameter int SYNTH_PHASE_ACC_BITS = 24,
  parameter int GLIDE_SHIFT          = 4,
  parameter int ENV_BITS             = 16,
  parameter int ENV_STEP             = 4096
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            sample_tick_in,
  input  logic                            note_valid_in,
  output logic                            note_ready_out,
  input  logic                            note_on_in,
  input  logic [SYNTH_PHASE_ACC_BITS-1:0] note_incr_in,
  output logic [SYNTH_PHASE_ACC_BITS-1:0] phase_incr_out,
  output logic [ENV_BITS-1:0]             gain_out,
  output logic                            active_out
);

  localparam int P = SYNTH_PHASE_ACC_BITS;

  localparam logic [ENV_BITS-1:0] GAIN_MAX  = '1;
  localparam logic [ENV_BITS-1:0] GAIN_STEP = ENV_BITS'(ENV_STEP);
  // Distances below this snap straight onto the target.
  localparam logic signed [P:0]   SNAP_LIM  = (P+1)'(1) << GLIDE_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_SUSTAIN,
    ST_RELEASE
  } env_state_e;

  env_state_e           state_q, state_d;
  logic [ENV_BITS-1:0]  gain_q, gain_d;
  logic [P-1:0]         cur_q, cur_d;
  logic [P-1:0]         tgt_q, tgt_d;
  logic                 slot_full_q, slot_full_d;
  logic                 slot_on_q, slot_on_d;
  logic [P-1:0]         slot_incr_q, slot_incr_d;
  logic                 ready_q, ready_d;
  logic                 active_q, active_d;
  logic                 direct_load;

  // One glide step: close 1/2^GLIDE_SHIFT of the gap, flooring toward -inf.
  // The floor never carries the result past the target, so no clamp needed.
  function automatic logic [P-1:0] glide_step(input logic [P-1:0] cur,
                                              input logic [P-1:0] tgt);
    logic signed [P:0] diff;
    logic signed [P:0] mag;
    logic signed [P:0] nxt;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = (diff < 0) ? -diff : diff;
    if (mag < SNAP_LIM) begin
      nxt = $signed({1'b0, tgt});
    end else begin
      nxt = $signed({1'b0, cur}) + (diff >>> GLIDE_SHIFT);
    end
    return nxt[P-1:0];
  endfunction

  // Attack step saturating at full scale.
  function automatic logic [ENV_BITS-1:0] attack_sat(input logic [ENV_BITS-1:0] g);
    logic [ENV_BITS:0] sum;
    sum = {1'b0, g} + {1'b0, GAIN_STEP};
    return (sum >= {1'b0, GAIN_MAX}) ? GAIN_MAX : sum[ENV_BITS-1:0];
  endfunction

  // Release step saturating at zero.
  function automatic logic [ENV_BITS-1:0] release_sat(input logic [ENV_BITS-1:0] g);
    return (g <= GAIN_STEP) ? '0 : g - GAIN_STEP;
  endfunction

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    slot_full_d = slot_full_q;
    slot_on_d   = slot_on_q;
    slot_incr_d = slot_incr_q;
    direct_load = 1'b0;

    if (sample_tick_in) begin
      // A slot filled at this very edge is not visible yet, so a request
      // captured in a tick cycle naturally waits for the next tick.
      if (slot_full_q) begin
        slot_full_d = 1'b0;
        if (slot_on_q) begin
          tgt_d = slot_incr_q;
          if (state_q == ST_IDLE) begin
            cur_d       = slot_incr_q;
            gain_d      = '0;
            direct_load = 1'b1;
          end
          state_d = ST_ATTACK;
        end else if (state_q == ST_ATTACK || state_q == ST_SUSTAIN) begin
          state_d = ST_RELEASE;
        end
      end

      if (state_d != ST_IDLE && !direct_load) begin
        cur_d = glide_step(cur_d, tgt_d);
      end

      case (state_d)
        ST_ATTACK: begin
          gain_d = attack_sat(gain_d);
          if (gain_d == GAIN_MAX) state_d = ST_SUSTAIN;
        end
        ST_SUSTAIN: gain_d = GAIN_MAX;
        ST_RELEASE: begin
          gain_d = release_sat(gain_d);
          if (gain_d == '0) begin
            state_d = ST_IDLE;
            cur_d   = '0;
          end
        end
        default: ;
      endcase
    end

    // ready_q high implies the slot is empty, so capture never collides
    // with consumption.
    if (note_valid_in && ready_q) begin
      slot_full_d = 1'b1;
      slot_on_d   = note_on_in;
      slot_incr_d = note_incr_in;
    end

    ready_d  = !slot_full_d;
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      gain_q      <= '0;
      cur_q       <= '0;
      tgt_q       <= '0;
      slot_full_q <= 1'b0;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      slot_full_q <= slot_full_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
    end
    slot_on_q   <= slot_on_d;
    slot_incr_q <= slot_incr_d;
  end

  assign note_ready_out = ready_q;
  assign phase_incr_out = cur_q;
  assign gain_out       = gain_q;
  assign active_out     = active_q;

endmodule

// File: tb/tb_synth_note_controller.sv
// Testbench for synth_note_controller: directed scenarios plus a randomized
// run, all compared against a behavioural note/envelope model.
module tb_synth_note_controller;

  localparam int     PB   = 24;
  localparam int     EB   = 16;
  localparam int     ES   = 4096;
  localparam int     GS   = 4;
  localparam longint GMAX = 65535;

  localparam int M_IDLE = 0;
  localparam int M_ATT  = 1;
  localparam int M_SUS  = 2;
  localparam int M_REL  = 3;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          sample_tick_in = 1'b0;
  logic          note_valid_in = 1'b0;
  logic          note_on_in = 1'b0;
  logic [PB-1:0] note_incr_in = '0;
  logic          note_ready_out;
  logic [PB-1:0] phase_incr_out;
  logic [EB-1:0] gain_out;
  logic          active_out;

  synth_note_controller #(
    .SYNTH_PHASE_ACC_BITS(PB),
    .GLIDE_SHIFT(GS),
    .ENV_BITS(EB),
    .ENV_STEP(ES)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .sample_tick_in(sample_tick_in),
    .note_valid_in(note_valid_in),
    .note_ready_out(note_ready_out),
    .note_on_in(note_on_in),
    .note_incr_in(note_incr_in),
    .phase_incr_out(phase_incr_out),
    .gain_out(gain_out),
    .active_out(active_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int tcnt     = 0;

  // Behavioural model state
  int     m_mode = M_IDLE;
  longint m_gain = 0;
  longint m_cur  = 0;
  longint m_tgt  = 0;
  longint m_incr = 0;
  bit     m_full = 0;
  bit     m_on   = 0;

  bit last_tick;
  bit last_acc;
  bit last_dut_acc;

  wire [PB+EB+1:0] dut_vec = {phase_incr_out, gain_out, active_out, note_ready_out};

  function automatic longint glide_toward(longint cur, longint tgt);
    longint d;
    longint div;
    div = longint'(1) << GS;
    d   = tgt - cur;
    if (d > -div && d < div) return tgt;
    if (d >= 0) return cur + d / div;
    return cur - ((-d + div - 1) / div);
  endfunction

  function automatic logic [PB+EB+1:0] model_vec();
    logic [PB-1:0] c;
    logic [EB-1:0] g;
    logic          a;
    logic          r;
    c = PB'(m_cur);
    g = EB'(m_gain);
    a = (m_mode != M_IDLE);
    r = !m_full;
    return {c, g, a, r};
  endfunction

  task automatic model_edge(input bit rst, input bit tick, input bit valid,
                            input bit on, input longint incr);
    bit acc;
    bit fresh;
    acc   = valid && !m_full && !rst;
    fresh = 0;
    if (rst) begin
      m_mode = M_IDLE; m_gain = 0; m_cur = 0; m_tgt = 0; m_full = 0;
      return;
    end
    if (tick) begin
      if (m_full) begin
        m_full = 0;
        if (m_on) begin
          if (m_mode == M_IDLE) begin
            m_cur  = m_incr;
            m_gain = 0;
            fresh  = 1;
          end
          m_tgt  = m_incr;
          m_mode = M_ATT;
        end else if (m_mode == M_ATT || m_mode == M_SUS) begin
          m_mode = M_REL;
        end
      end
      if (m_mode != M_IDLE && !fresh) m_cur = glide_toward(m_cur, m_tgt);
      if (m_mode == M_ATT) begin
        if (m_gain + ES >= GMAX) begin m_gain = GMAX; m_mode = M_SUS; end
        else m_gain = m_gain + ES;
      end else if (m_mode == M_SUS) begin
        m_gain = GMAX;
      end else if (m_mode == M_REL) begin
        if (m_gain <= ES) begin m_gain = 0; m_mode = M_IDLE; m_cur = 0; end
        else m_gain = m_gain - ES;
      end
    end
    if (acc) begin
      m_full = 1; m_on = on; m_incr = incr;
    end
  endtask

  // One clock cycle; a tick occurs every 8th cycle.
  task automatic cycle(input bit rst, input bit valid, input bit on,
                       input logic [PB-1:0] incr);
    bit tick;
    tick = (tcnt == 7);
    tcnt = (tcnt + 1) % 8;
    rst_in         = rst;
    sample_tick_in = tick;
    note_valid_in  = valid;
    note_on_in     = on;
    note_incr_in   = incr;
    last_tick      = tick;
    last_acc       = valid && !m_full && !rst;
    last_dut_acc   = valid && note_ready_out && !rst;
    @(posedge clk_in);
    model_edge(rst, tick, valid, on, longint'(incr));
    #1;
  endtask

  task automatic run_ticks(input int n);
    int cnt;
    cnt = 0;
    while (cnt < n) begin
      cycle(0, 0, 0, '0);
      if (last_tick) cnt++;
    end
  endtask

  task automatic send(input bit on, input logic [PB-1:0] incr, input string tag);
    int n;
    n = 0;
    do begin
      cycle(0, 1, on, incr);
      n++;
    end while (!last_dut_acc && n < 64);
    note_valid_in = 1'b0;
    checks++;
    if (!last_dut_acc) begin
      failures++;
      $display("FAIL %s_accept got=no_transfer want=transfer within 64 cycles", tag);
    end
  endtask

  task automatic test_reset();
    tcnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 24'd777);
      checks++;
      if (dut_vec !== {{PB{1'b0}}, {EB{1'b0}}, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset_hold got=%h want=%h", dut_vec, {{PB{1'b0}}, {EB{1'b0}}, 1'b0, 1'b1});
      end
    end
    cycle(0, 0, 0, '0);
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_attack();
    send(1, 24'd1000, "attack");
    checks++;
    if (note_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL attack_ready_low got=%b want=0", note_ready_out);
    end
    run_ticks(1);
    checks++;
    if ({phase_incr_out, gain_out, active_out} !== {24'd1000, 16'd4096, 1'b1}) begin
      failures++;
      $display("FAIL attack_tick1 got=%0d/%0d/%b want=1000/4096/1", phase_incr_out, gain_out, active_out);
    end
    run_ticks(14);
    checks++;
    if (gain_out !== 16'd61440) begin
      failures++;
      $display("FAIL attack_tick15 got=%0d want=61440", gain_out);
    end
    run_ticks(1);
    checks++;
    if (gain_out !== 16'd65535 || active_out !== 1'b1) begin
      failures++;
      $display("FAIL attack_tick16 got=%0d/%b want=65535/1", gain_out, active_out);
    end
    run_ticks(3);
    checks++;
    if (gain_out !== 16'd65535 || dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL sustain_hold got=%h want=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_glide();
    int n;
    send(1, 24'd2000, "glide_up");
    run_ticks(1);
    checks++;
    if (phase_incr_out !== 24'd1062) begin
      failures++;
      $display("FAIL glide_up_first got=%0d want=1062", phase_incr_out);
    end
    n = 0;
    while (phase_incr_out != 24'd2000 && n < 100) begin
      run_ticks(1);
      n++;
      checks++;
      if (phase_incr_out > 24'd2000 || dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL glide_up_step got=%h want=%h", dut_vec, model_vec());
      end
    end
    checks++;
    if (phase_incr_out !== 24'd2000) begin
      failures++;
      $display("FAIL glide_up_converge got=%0d want=2000", phase_incr_out);
    end
    send(1, 24'd1000, "glide_down");
    run_ticks(1);
    checks++;
    if (phase_incr_out !== 24'd1937) begin
      failures++;
      $display("FAIL glide_down_first got=%0d want=1937", phase_incr_out);
    end
    n = 0;
    while (phase_incr_out != 24'd1000 && n < 100) begin
      run_ticks(1);
      n++;
      checks++;
      if (phase_incr_out < 24'd1000 || dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL glide_down_step got=%h want=%h", dut_vec, model_vec());
      end
    end
    checks++;
    if (phase_incr_out !== 24'd1000) begin
      failures++;
      $display("FAIL glide_down_converge got=%0d want=1000", phase_incr_out);
    end
  endtask

  task automatic test_release();
    int     k;
    longint expv;
    send(0, '0, "release");
    k = 0;
    do begin
      run_ticks(1);
      k++;
      expv = GMAX - longint'(ES) * k;
      if (expv < 0) expv = 0;
      checks++;
      if (longint'(gain_out) != expv) begin
        failures++;
        $display("FAIL release_gain tick=%0d got=%0d want=%0d", k, gain_out, expv);
      end
    end while (active_out && k < 20);
    checks++;
    if (k != 16 || {phase_incr_out, gain_out, active_out} !== {24'd0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL release_idle ticks=%0d got=%0d/%0d/%b want=16 ticks 0/0/0", k, phase_incr_out, gain_out, active_out);
    end
  endtask

  task automatic test_retrigger();
    send(1, 24'd1000, "retrig_on");
    run_ticks(16);
    send(0, '0, "retrig_off");
    run_ticks(11);
    checks++;
    if (gain_out !== 16'd20479) begin
      failures++;
      $display("FAIL retrig_release_gain got=%0d want=20479", gain_out);
    end
    send(1, 24'd3000, "retrig_again");
    run_ticks(1);
    checks++;
    if (gain_out !== 16'd24575 || active_out !== 1'b1 || dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL retrig_attack got=%h want=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    bit  prev_tick;
    logic [PB-1:0] ph_before;
    cycle(0, 1, 1, 24'd5000);
    checks++;
    if (!last_dut_acc) begin
      failures++;
      $display("FAIL b2b_first got=no_transfer want=transfer");
    end
    n = 0;
    prev_tick = last_tick;
    do begin
      prev_tick = last_tick;
      cycle(0, 1, 1, 24'd7000);
      n++;
      checks++;
      if (last_dut_acc !== last_acc || dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL b2b_stall cyc=%0d acc=%b want_acc=%b got=%h want=%h", n, last_dut_acc, last_acc, dut_vec, model_vec());
      end
    end while (!last_dut_acc && n < 20);
    note_valid_in = 1'b0;
    checks++;
    if (!last_dut_acc || !prev_tick) begin
      failures++;
      $display("FAIL b2b_second acc=%b after_tick=%b want=1/1", last_dut_acc, prev_tick);
    end
    run_ticks(1);
    while (tcnt != 7) cycle(0, 0, 0, '0);
    ph_before = phase_incr_out;
    cycle(0, 1, 1, 24'd9000);
    checks++;
    if (!(last_tick && last_dut_acc) || dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL tick_capture tick=%b acc=%b got=%h want=%h", last_tick, last_dut_acc, dut_vec, model_vec());
    end
    run_ticks(1);
    checks++;
    if (phase_incr_out <= ph_before || dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL tick_capture_apply got=%h want=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, '0);
    send(1, 24'd1000, "rstmid_on");
    run_ticks(2);
    checks++;
    if (gain_out !== 16'd8192) begin
      failures++;
      $display("FAIL rstmid_gain got=%0d want=8192", gain_out);
    end
    send(1, 24'd9000, "rstmid_pending");
    cycle(1, 0, 0, '0);
    checks++;
    if (dut_vec !== {{PB{1'b0}}, {EB{1'b0}}, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_reset got=%h want=%h", dut_vec, {{PB{1'b0}}, {EB{1'b0}}, 1'b0, 1'b1});
    end
    run_ticks(3);
    checks++;
    if ({phase_incr_out, gain_out, active_out, note_ready_out} !== {24'd0, 16'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_discard got=%h want=idle", dut_vec);
    end
  endtask

  task automatic test_random();
    bit            r;
    bit            v;
    bit            o;
    logic [PB-1:0] inc;
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) == 0);
      o   = ($urandom_range(0, 9) < 7);
      inc = ($urandom_range(0, 1) == 0) ? PB'($urandom_range(0, 16777215))
                                        : PB'($urandom_range(0, 100));
      cycle(r, v, o, inc);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_glide();
    test_release();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
